// File: rtl/hall_sequence_generator.sv
// ============================================================================
// Module   : hall_sequence_generator
// Purpose  : Emits a legal six-step HALL code sequence at a commanded direction,
//            step period and step count. Optional macro: HALL_SEQ_FAULT_INJECT_EN
//            (adds fault_inject / fault_code override of hall_values).
// Encodings: cmd_direction 2'b00=DIR_NONE, 2'b01=DIR_CW, 2'b10=DIR_CCW
//            (2'b11 is treated as DIR_NONE). hall_values = {C,B,A}.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hall_sequence_generator #(
    parameter int COUNTER_WIDTH = 32,
    parameter int INIT_SECTOR   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_direction,
    input  logic [COUNTER_WIDTH-1:0] cmd_step_ticks,
    input  logic [COUNTER_WIDTH-1:0] cmd_steps,
    input  logic                     stop,
`ifdef HALL_SEQ_FAULT_INJECT_EN
    input  logic                     fault_inject,
    input  logic [2:0]               fault_code,
`endif
    output logic [2:0]               hall_values,
    output logic [2:0]               sector,
    output logic [COUNTER_WIDTH-1:0] position,
    output logic                     step_strobe,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0] c_dir_cw  = 2'b01;
    localparam logic [1:0] c_dir_ccw = 2'b10;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    localparam logic [2:0]               c_init_sector = 3'(INIT_SECTOR);
    localparam logic [COUNTER_WIDTH-1:0] c_one         = COUNTER_WIDTH'(1);

    // Sector to HALL code: 0=AC 1=A 2=AB 3=B 4=BC 5=C (one bit changes per step)
    function automatic logic [2:0] f_hall(input logic [2:0] s);
        case (s)
            3'd0:    return 3'b101;
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b110;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] f_sector_step(input logic [2:0] s, input logic cw);
        if (cw) begin
            return (s == 3'd5) ? 3'd0 : s + 3'd1;
        end
        return (s == 3'd0) ? 3'd5 : s - 3'd1;
    endfunction

    logic [0:0]               r_state,     w_state_next;
    logic [COUNTER_WIDTH-1:0] r_period,    w_period_next;
    logic [COUNTER_WIDTH-1:0] r_remaining, w_remaining_next;
    logic [COUNTER_WIDTH-1:0] r_ticks,     w_ticks_next;
    logic                     r_dir_cw,    w_dir_cw_next;
    logic                     r_last,      w_last_next;
    logic [2:0]               r_sector,    w_sector_next;
    logic [COUNTER_WIDTH-1:0] r_position,  w_position_next;
    logic [2:0]               r_hall,      w_hall_next;
    logic                     r_strobe,    w_strobe_next;
    logic                     r_done,      w_done_next;
    logic [COUNTER_WIDTH-1:0] w_cmd_period;

    assign w_cmd_period = (cmd_step_ticks == '0) ? c_one : cmd_step_ticks;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_period    <= c_one;
            r_remaining <= '0;
            r_ticks     <= '0;
            r_dir_cw    <= 1'b0;
            r_last      <= 1'b0;
            r_sector    <= c_init_sector;
            r_position  <= '0;
            r_hall      <= f_hall(c_init_sector);
            r_strobe    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_period    <= w_period_next;
            r_remaining <= w_remaining_next;
            r_ticks     <= w_ticks_next;
            r_dir_cw    <= w_dir_cw_next;
            r_last      <= w_last_next;
            r_sector    <= w_sector_next;
            r_position  <= w_position_next;
            r_hall      <= w_hall_next;
            r_strobe    <= w_strobe_next;
            r_done      <= w_done_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_period_next    = r_period;
        w_remaining_next = r_remaining;
        w_ticks_next     = r_ticks;
        w_dir_cw_next    = r_dir_cw;
        w_last_next      = r_last;
        w_sector_next    = r_sector;
        w_position_next  = r_position;
        w_strobe_next    = 1'b0;
        w_done_next      = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (cmd_valid) begin
                    if ((cmd_direction == c_dir_cw) || (cmd_direction == c_dir_ccw)) begin
                        w_state_next     = c_st_run;
                        w_period_next    = w_cmd_period;
                        w_remaining_next = cmd_steps;
                        w_ticks_next     = '0;
                        w_dir_cw_next    = (cmd_direction == c_dir_cw);
                        w_last_next      = 1'b0;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            default: begin
                // stop wins over both a due step and the completion cycle
                if (stop) begin
                    w_state_next = c_st_idle;
                end else if (r_last) begin
                    w_state_next = c_st_idle;
                    w_done_next  = 1'b1;
                end else if (r_ticks == (r_period - c_one)) begin
                    w_ticks_next    = '0;
                    w_sector_next   = f_sector_step(r_sector, r_dir_cw);
                    w_position_next = r_dir_cw ? (r_position + c_one) : (r_position - c_one);
                    w_strobe_next   = 1'b1;
                    w_last_next     = (r_remaining == c_one);
                    // remaining of zero marks a continuous run and is never decremented
                    if (r_remaining != '0) begin
                        w_remaining_next = r_remaining - c_one;
                    end
                end else begin
                    w_ticks_next = r_ticks + c_one;
                end
            end
        endcase
    end

`ifdef HALL_SEQ_FAULT_INJECT_EN
    assign w_hall_next = fault_inject ? fault_code : f_hall(w_sector_next);
`else
    assign w_hall_next = f_hall(w_sector_next);
`endif

    assign cmd_ready   = (r_state == c_st_idle);
    assign busy        = (r_state == c_st_run);
    assign hall_values = r_hall;
    assign sector      = r_sector;
    assign position    = r_position;
    assign step_strobe = r_strobe;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hall_sequence_generator.sv
// ============================================================================
// Module   : tb_hall_sequence_generator
// Purpose  : Self-checking bench; expected outputs come from a cycle-count
//            model of step times (step k lands k*period cycles after accept).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hall_sequence_generator;

    localparam int W    = 32;
    localparam int INIT = 0;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_CW   = 2'b01;
    localparam logic [1:0] DIR_CCW  = 2'b10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_direction = DIR_NONE;
    logic [W-1:0] cmd_step_ticks = '0;
    logic [W-1:0] cmd_steps = '0;
    logic         stop = 1'b0;
    logic         fault_inject = 1'b0;
    logic [2:0]   fault_code = 3'b000;
    logic [2:0]   hall_values;
    logic [2:0]   sector;
    logic [W-1:0] position;
    logic         step_strobe;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    int         m_sector;
    logic [W-1:0] m_pos;
    logic [2:0] hall_map [6] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

    always #5 clk = ~clk;

    hall_sequence_generator #(.COUNTER_WIDTH(W), .INIT_SECTOR(INIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_direction  (cmd_direction),
        .cmd_step_ticks (cmd_step_ticks),
        .cmd_steps      (cmd_steps),
        .stop           (stop),
`ifdef HALL_SEQ_FAULT_INJECT_EN
        .fault_inject   (fault_inject),
        .fault_code     (fault_code),
`endif
        .hall_values    (hall_values),
        .sector         (sector),
        .position       (position),
        .step_strobe    (step_strobe),
        .busy           (busy),
        .done           (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, " sector"},   32'(sector),      32'(m_sector));
        check({tag, " hall"},     32'(hall_values), 32'(hall_map[m_sector]));
        check({tag, " position"}, position,         m_pos);
        check({tag, " busy"},     32'(busy),        32'd0);
        check({tag, " ready"},    32'(cmd_ready),   32'd1);
        check({tag, " strobe"},   32'(step_strobe), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        m_sector = INIT;
        m_pos    = '0;
        check_idle_state("reset");
        check("reset done", 32'(done), 32'd0);
        reset = 1'b0;
    endtask

    // One command from accept to settle; the model derives every output from
    // the cycle index c relative to the accept edge.
    task automatic run_cmd(input logic [1:0] dir, input int ticks, input int steps,
                           input int stop_at, input int reset_at, input bit hold_valid,
                           input int f_lo, input int f_hi, input logic [2:0] fcode);
        int  p, sgn, last_c;
        bit  stopped, stepped, exp_done, exp_busy, in_fault;
        p = (ticks == 0) ? 1 : ticks;
        cmd_valid      = 1'b1;
        cmd_direction  = dir;
        cmd_step_ticks = 32'(ticks);
        cmd_steps      = 32'(steps);
        tick();
        if (hold_valid) begin
            cmd_direction  = (dir == DIR_CW) ? DIR_CCW : DIR_CW;
            cmd_step_ticks = 32'd1;
            cmd_steps      = 32'd1;
        end else begin
            cmd_valid = 1'b0;
        end
        if (dir != DIR_CW && dir != DIR_CCW) begin
            check("none done", 32'(done), 32'd1);
            check_idle_state("none");
            tick();
            check("none done once", 32'(done), 32'd0);
            check_idle_state("none after");
            return;
        end
        check("accept busy",  32'(busy),        32'd1);
        check("accept ready", 32'(cmd_ready),   32'd0);
        check("accept strobe",32'(step_strobe), 32'd0);
        sgn    = (dir == DIR_CW) ? 1 : -1;
        last_c = (steps == 0) ? stop_at + 1 : steps * p + 2;
        if (stop_at != 0 && stop_at + 1 < last_c) last_c = stop_at + 1;
        if (reset_at != 0) last_c = reset_at;
        for (int c = 1; c <= last_c; c++) begin
            stop         = (c == stop_at);
            reset        = (c == reset_at);
            in_fault     = (c >= f_lo) && (c < f_hi);
            fault_inject = in_fault;
            fault_code   = fcode;
            if (hold_valid && c > steps * p + 1) cmd_valid = 1'b0;
            tick();
            stop  = 1'b0;
            reset = 1'b0;
            if (c == reset_at) begin
                m_sector = INIT;
                m_pos    = '0;
                check_idle_state("midrun reset");
                check("midrun reset done", 32'(done), 32'd0);
                break;
            end
            stopped  = (stop_at != 0) && (c >= stop_at);
            stepped  = !stopped && (c % p == 0) && (steps == 0 || c / p <= steps);
            if (stepped) begin
                m_sector = (m_sector + sgn + 6) % 6;
                m_pos    = (sgn > 0) ? m_pos + 32'd1 : m_pos - 32'd1;
            end
            exp_done = !stopped && steps != 0 && c == steps * p + 1;
            exp_busy = !stopped && !(steps != 0 && c >= steps * p + 1);
            check("strobe",   32'(step_strobe), 32'(stepped));
            check("sector",   32'(sector),      32'(m_sector));
            check("hall",     32'(hall_values), in_fault ? 32'(fcode) : 32'(hall_map[m_sector]));
            check("position", position,         m_pos);
            check("busy",     32'(busy),        32'(exp_busy));
            check("ready",    32'(cmd_ready),   32'(!exp_busy));
            check("done",     32'(done),        32'(exp_done));
        end
        cmd_valid    = 1'b0;
        fault_inject = 1'b0;
    endtask

    initial begin
        int d, t, s, p, sa;
        do_reset();

        run_cmd(DIR_CW, 4, 7, 0, 0, 0, 0, 0, 3'b000);
        check("cw7 final sector",   32'(sector), 32'd1);
        check("cw7 final position", position,    32'd7);

        do_reset();
        run_cmd(DIR_CCW, 1, 3, 0, 0, 0, 0, 0, 3'b000);
        check("ccw3 final sector",   32'(sector), 32'd3);
        check("ccw3 final position", position,    32'hFFFF_FFFD);

        do_reset();
        run_cmd(DIR_CW, 10, 0, 20, 0, 0, 0, 0, 3'b000);
        check("stop sector",   32'(sector), 32'd1);
        check("stop position", position,    32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stop quiet strobe", 32'(step_strobe), 32'd0);
            check("stop quiet done",   32'(done),        32'd0);
        end

        run_cmd(DIR_NONE, 5, 5, 0, 0, 0, 0, 0, 3'b000);
        run_cmd(DIR_CW, 2, 3, 0, 0, 1, 0, 0, 3'b000);
        run_cmd(DIR_CCW, 0, 4, 0, 0, 0, 0, 0, 3'b000);

        for (int i = 0; i < 10; i++) begin
            d  = $urandom_range(0, 2);
            t  = $urandom_range(0, 5);
            s  = $urandom_range(0, 6);
            p  = (t == 0) ? 1 : t;
            if (s == 0)                          sa = $urandom_range(1, 3 * p + 1);
            else if ($urandom_range(0, 3) == 0)  sa = $urandom_range(1, s * p);
            else                                 sa = 0;
            run_cmd(2'(d), t, s, sa, 0, 0, 0, 0, 3'b000);
        end

        run_cmd(DIR_CW, 3, 0, 0, 9, 0, 0, 0, 3'b000);

`ifdef HALL_SEQ_FAULT_INJECT_EN
        run_cmd(DIR_CW, 2, 6, 0, 0, 0, 3, 8, 3'b111);
        run_cmd(DIR_CCW, 1, 4, 0, 0, 0, 1, 3, 3'b000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
